inst_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the instruction memory (`InstMem`). Holds the program counter, drives the memory's word read address, captures the returned 32-bit word into the IF/ID pipeline register, and handles stalls, branch redirects, memory-busy bubbles and a halt instruction. Its outputs feed the decode stage.

---
 rtl/inst_fetch.sv | 95 +++++++++
 tb/tb_inst_fetch.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, reads InstMem combinationally and
// registers the returned word into IF/ID with stall, redirect, bubble and halt handling.
module inst_fetch #(
   parameter int unsigned           ADDR_W    = 10,
   parameter int unsigned           DATA_W    = 32,
   parameter logic [ADDR_W-1:0]     RESET_PC  = '0,
   parameter logic [DATA_W-1:0]     HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_addr,
   input  logic              im_busy,
   output logic [ADDR_W-1:0] im_addr,
   input  logic [DATA_W-1:0] im_data,
   output logic [DATA_W-1:0] ifid_inst,
   output logic [ADDR_W-1:0] ifid_pc,
   output logic              ifid_valid,
   output logic              halted,
   output logic [15:0]       fetch_cnt
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_t;

   localparam logic [ADDR_W-1:0] PC_INC = {{(ADDR_W-1){1'b0}}, 1'b1};

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic [DATA_W-1:0]   inst_q, inst_d;
   logic [ADDR_W-1:0]   ipc_q, ipc_d;
   logic                valid_q, valid_d;
   logic [15:0]         cnt_q, cnt_d;

   // Priority: redirect > stall > halt > busy bubble > fetch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      ipc_d   = ipc_q;
      valid_d = valid_q;
      cnt_d   = cnt_q;
      if (redirect) begin
         pc_d    = redirect_addr;
         valid_d = 1'b0;
         state_d = S_RUN;
      end else if (stall) begin
         state_d = state_q;
      end else if (state_q == S_HALT) begin
         valid_d = 1'b0;
      end else if (im_busy) begin
         valid_d = 1'b0;
      end else begin
         inst_d  = im_data;
         ipc_d   = pc_q;
         valid_d = 1'b1;
         cnt_d   = cnt_q + 16'd1;
         // The halt word is delivered and counted, but the PC parks on it.
         if (im_data == HALT_WORD) begin
            state_d = S_HALT;
         end else begin
            pc_d = pc_q + PC_INC;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_RUN;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         ipc_q   <= '0;
         valid_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         ipc_q   <= ipc_d;
         valid_q <= valid_d;
         cnt_q   <= cnt_d;
      end
   end

   assign im_addr    = pc_q;
   assign ifid_inst  = inst_q;
   assign ifid_pc    = ipc_q;
   assign ifid_valid = valid_q;
   assign halted     = (state_q == S_HALT);
   assign fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios then random stall/busy/redirect traffic,
// all compared against a cycle-level model of the fetch rules.
module tb_inst_fetch;

   localparam logic [31:0] HALTW = 32'hFFFF_FFFF;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, redirect, im_busy;
   logic [9:0]  redirect_addr;
   logic [9:0]  im_addr;
   logic [31:0] im_data;
   logic [31:0] ifid_inst;
   logic [9:0]  ifid_pc;
   logic        ifid_valid;
   logic        halted;
   logic [15:0] fetch_cnt;

   logic [31:0] mem [1024];

   int tests = 0;
   int fails = 0;

   // model state
   int          m_pc;
   bit          m_halt;
   logic [31:0] m_inst;
   int          m_ipc;
   bit          m_valid;
   int          m_cnt;

   always #5 clk = ~clk;

   assign im_data = mem[im_addr];

   inst_fetch #(
      .ADDR_W   (10),
      .DATA_W   (32),
      .RESET_PC (10'd0),
      .HALT_WORD(HALTW)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .redirect     (redirect),
      .redirect_addr(redirect_addr),
      .im_busy      (im_busy),
      .im_addr      (im_addr),
      .im_data      (im_data),
      .ifid_inst    (ifid_inst),
      .ifid_pc      (ifid_pc),
      .ifid_valid   (ifid_valid),
      .halted       (halted),
      .fetch_cnt    (fetch_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_halt = 0; m_inst = '0; m_ipc = 0; m_valid = 0; m_cnt = 0;
   endtask

   task automatic model_step(input bit st, input bit bsy, input bit rd, input int ra);
      logic [31:0] w;
      if (rd) begin
         m_pc = ra; m_valid = 0; m_halt = 0;
      end else if (st) begin
         // everything frozen
      end else if (m_halt || bsy) begin
         m_valid = 0;
      end else begin
         w       = mem[m_pc];
         m_inst  = w;
         m_ipc   = m_pc;
         m_valid = 1;
         m_cnt   = (m_cnt + 1) % 65536;
         if (w == HALTW) m_halt = 1;
         else            m_pc = (m_pc + 1) % 1024;
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".im_addr"}, 32'(im_addr),    32'(m_pc));
      check({tag, ".valid"},   32'(ifid_valid), 32'(m_valid));
      check({tag, ".halted"},  32'(halted),     32'(m_halt));
      check({tag, ".cnt"},     32'(fetch_cnt),  32'(m_cnt));
      check({tag, ".inst"},    ifid_inst,       m_inst);
      check({tag, ".pc"},      32'(ifid_pc),    32'(m_ipc));
   endtask

   // Drive inputs (called just after a falling edge), step one rising edge, compare.
   task automatic cycle(input string tag, input bit st, input bit bsy, input bit rd, input int ra);
      stall = st; im_busy = bsy; redirect = rd; redirect_addr = 10'(ra);
      @(posedge clk);
      #1;
      model_step(st, bsy, rd, ra);
      compare_all(tag);
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; stall = 0; redirect = 0; im_busy = 0; redirect_addr = '0;
      for (int i = 0; i < 1024; i++) begin
         mem[i] = $urandom;
         if (mem[i] == HALTW) mem[i] = 32'h0;
      end
      mem[0] = 32'd47; mem[1] = 32'd74; mem[2] = 32'd5; mem[3] = HALTW;
      mem[4] = 32'h0000_1234; mem[100] = 32'hCAFE_0100; mem[1023] = 32'hBEEF_03FF;
      model_reset();
      #1;
      compare_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // sequential fetch, then stall x2 and busy x1 after address 1
      cycle("seq0", 0, 0, 0, 0);
      check("seq0_inst", ifid_inst, 32'd47);
      cycle("seq1", 0, 0, 0, 0);
      check("seq1_inst", ifid_inst, 32'd74);
      for (int i = 0; i < 2; i++) begin
         cycle("stall", 1, 0, 0, 0);
         check("stall_pc", 32'(ifid_pc), 32'd1);
         check("stall_addr", 32'(im_addr), 32'd2);
      end
      cycle("busy", 0, 1, 0, 0);
      check("busy_valid", 32'(ifid_valid), 32'd0);
      cycle("seq2", 0, 0, 0, 0);
      check("seq2_inst", ifid_inst, 32'd5);
      check("seq2_cnt", 32'(fetch_cnt), 32'd3);

      // halt at address 3
      cycle("halt_fetch", 0, 0, 0, 0);
      check("halt_word", ifid_inst, HALTW);
      check("halt_valid", 32'(ifid_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         cycle("halted", 0, 0, 0, 0);
         check("halted_flag", 32'(halted), 32'd1);
         check("halted_addr", 32'(im_addr), 32'd3);
      end
      cycle("halt_redir", 0, 0, 1, 0);
      check("halt_cleared", 32'(halted), 32'd0);
      cycle("restart0", 0, 0, 0, 0);
      check("restart_inst", ifid_inst, 32'd47);

      // redirect under stall with PC = 5
      cycle("to4", 0, 0, 1, 4);
      cycle("fetch4", 0, 0, 0, 0);
      check("pc5", 32'(im_addr), 32'd5);
      cycle("redir_stall", 1, 0, 1, 100);
      check("redir_valid", 32'(ifid_valid), 32'd0);
      check("redir_addr", 32'(im_addr), 32'd100);
      cycle("fetch100", 0, 0, 0, 0);
      check("fetch100_inst", ifid_inst, 32'hCAFE_0100);

      // PC wrap
      cycle("to1023", 0, 0, 1, 1023);
      cycle("wrapA", 0, 0, 0, 0);
      check("wrap_pc1023", 32'(ifid_pc), 32'd1023);
      cycle("wrapB", 0, 0, 0, 0);
      check("wrap_pc0", 32'(ifid_pc), 32'd0);

      // asynchronous reset between edges
      cycle("prerst", 0, 0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      compare_all("async_rst");
      check("rst_valid", 32'(ifid_valid), 32'd0);
      check("rst_cnt", 32'(fetch_cnt), 32'd0);
      @(posedge clk);
      #1;
      compare_all("rst_hold");
      @(negedge clk);
      reset = 1'b0;
      cycle("post_rst", 0, 0, 0, 0);
      check("post_rst_pc", 32'(ifid_pc), 32'd0);

      // random traffic with a few halt words scattered in memory
      for (int i = 0; i < 12; i++) mem[$urandom_range(5, 1023)] = HALTW;
      for (int i = 0; i < 400; i++) begin
         cycle("rand", ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
               ($urandom_range(0, 99) < 8), int'($urandom_range(0, 1023)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
